custom_axi_ip_csr: RTL

//  AXI4-Lite slave register front-end that drives the register-to-hardware interface of the custom IP engine.
//  - Software writes a 64-bit operand and a START command; the block presents the operand and pulses enable.
//  - It captures the engine's result when the write-enable strobe arrives.
//  - It exposes result and status for readback, with a timeout guard.
//  - Sits between the SoC AXI-Lite interconnect and the IP engine.

---
 rtl/custom_axi_ip_csr.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/custom_axi_ip_csr.sv
// AXI4-Lite register front-end for the IP engine: operand/launch, result capture, sticky status, IRQ.
// Responses one cycle after the handshake; AW/W held until B accepts, AR stalled while R is pending.
module custom_axi_ip_csr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                    s_awvalid_i,
    output logic                    s_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
    input  logic                    s_wvalid_i,
    output logic                    s_wready_o,
    output logic [1:0]              s_bresp_o,
    output logic                    s_bvalid_o,
    input  logic                    s_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
    input  logic                    s_arvalid_i,
    output logic                    s_arready_o,
    output logic [DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]              s_rresp_o,
    output logic                    s_rvalid_o,
    input  logic                    s_rready_i,
    output logic [63:0]             ipreg_data_o,
    output logic                    enable_o,
    input  logic [63:0]             ipreg_data_i,
    input  logic                    wen_i,
    input  logic [1:0]              status_i,
    output logic                    irq_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_aw_held, r_w_held, r_aw_oob;
    logic [2:0]              r_aw_idx;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [DATA_WIDTH/8-1:0] r_w_strb;
    logic                    r_bvalid, r_rvalid;
    logic [1:0]              r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [31:0]             r_data_lo, r_data_hi;
    logic [63:0]             r_result;
    logic                    r_irq_en, r_done, r_timeout;
    logic [1:0]              r_status_smp;
    logic [CW-1:0]           r_tmo_cnt;

    logic                    w_busy, w_wr_fire, w_wr_err, w_start, w_tmo_hit, w_res_cap;
    logic                    w_wr_lo, w_wr_hi, w_wr_ctrl, w_wr_stat;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [1:0]              w_rd_resp;
    logic                    w_unused;

    assign w_unused = &{1'b0, s_awaddr_i[1:0], s_araddr_i[1:0]};

    assign s_awready_o  = !r_aw_held && !r_bvalid;
    assign s_wready_o   = !r_w_held && !r_bvalid;
    assign s_arready_o  = !r_rvalid;
    assign s_bvalid_o   = r_bvalid;
    assign s_bresp_o    = r_bresp;
    assign s_rvalid_o   = r_rvalid;
    assign s_rresp_o    = r_rresp;
    assign s_rdata_o    = r_rdata;
    assign ipreg_data_o = {r_data_hi, r_data_lo};
    assign irq_o        = (r_done | r_timeout) & r_irq_en;

    assign w_wr_fire = r_aw_held && r_w_held;
    assign w_tmo_hit = (r_state == S_WAIT) && !wen_i && (r_tmo_cnt == TMO_LAST);
    assign w_res_cap = (r_state == S_WAIT) && wen_i;

    // Write decode; a busy engine rejects operand writes and a second START.
    always_comb begin
        w_wr_err  = 1'b0;
        w_wr_lo   = 1'b0;
        w_wr_hi   = 1'b0;
        w_wr_ctrl = 1'b0;
        w_wr_stat = 1'b0;
        if (r_aw_oob) begin
            w_wr_err = 1'b1;
        end else begin
            case (r_aw_idx)
                3'd0: if (w_busy) w_wr_err = 1'b1; else w_wr_lo = 1'b1;
                3'd1: if (w_busy) w_wr_err = 1'b1; else w_wr_hi = 1'b1;
                3'd2: begin
                    w_wr_ctrl = 1'b1;
                    if (w_busy && r_w_strb[0] && r_w_data[0]) w_wr_err = 1'b1;
                end
                3'd3: w_wr_stat = 1'b1;
                default: w_wr_err = 1'b1;
            endcase
        end
        w_wr_lo   = w_wr_lo & w_wr_fire;
        w_wr_hi   = w_wr_hi & w_wr_fire;
        w_wr_ctrl = w_wr_ctrl & w_wr_fire & r_w_strb[0];
        w_wr_stat = w_wr_stat & w_wr_fire & r_w_strb[0];
    end

    assign w_start = w_wr_ctrl && r_w_data[0] && !w_busy;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (|s_araddr_i[ADDR_WIDTH-1:5]) begin
            w_rd_resp = RESP_SLVERR;
        end else begin
            case (s_araddr_i[4:2])
                3'd0: w_rd_data = r_data_lo;
                3'd1: w_rd_data = r_data_hi;
                3'd2: w_rd_data = {30'd0, r_irq_en, 1'b0};
                3'd3: w_rd_data = {27'd0, r_timeout, r_done, w_busy, r_status_smp};
                3'd4: w_rd_data = r_result[31:0];
                3'd5: w_rd_data = r_result[63:32];
                default: w_rd_resp = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_held <= 1'b0;
            r_aw_oob  <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (s_awvalid_i && s_awready_o) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= s_awaddr_i[4:2];
                    r_aw_oob  <= |s_awaddr_i[ADDR_WIDTH-1:5];
                end
                if (s_wvalid_i && s_wready_o) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_wdata_i;
                    r_w_strb <= s_wstrb_i;
                end
                if (r_bvalid && s_bready_i) r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_arvalid_i && s_arready_o) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_lo    <= '0;
            r_data_hi    <= '0;
            r_irq_en     <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_result     <= '0;
            r_status_smp <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_status_smp <= status_i;
            for (int i = 0; i < 4; i++) begin
                if (w_wr_lo && r_w_strb[i]) r_data_lo[8*i +: 8] <= r_w_data[8*i +: 8];
                if (w_wr_hi && r_w_strb[i]) r_data_hi[8*i +: 8] <= r_w_data[8*i +: 8];
            end
            if (w_wr_ctrl) r_irq_en <= r_w_data[1];
            // Sets take priority over the launch clear and the W1C clear.
            if (w_res_cap) r_done <= 1'b1;
            else if (r_state == S_LAUNCH) r_done <= 1'b0;
            else if (w_wr_stat && r_w_data[3]) r_done <= 1'b0;
            if (w_tmo_hit) r_timeout <= 1'b1;
            else if (r_state == S_LAUNCH) r_timeout <= 1'b0;
            else if (w_wr_stat && r_w_data[4]) r_timeout <= 1'b0;
            if (w_res_cap) r_result <= ipreg_data_i;
            if (r_state == S_LAUNCH) r_tmo_cnt <= '0;
            else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (wen_i || w_tmo_hit) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        enable_o = (r_state == S_LAUNCH);
        w_busy   = (r_state != S_IDLE);
    end

endmodule
